// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared definitions for the register-file access arbiter:
//   state_e          - transaction FSM states
//   PORT0 / PORT1    - grant identifiers (also the encoding of last_grant)
//   DEFAULT_TIMEOUT  - default number of WAIT_RD cycles before a read aborts
//   CNT_WIDTH        - width of the read timeout counter (TIMEOUT <= 255)
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;
  localparam int CNT_WIDTH       = 8;

endpackage : regfile_arb_pkg

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   valid_i[1:0]  in   request bits, index = port number
//   last_grant_i  in   port that won the previous transaction
//   grant_o[1:0]  out  one-hot grant (all zero when nothing is requested)
// A lone requester always wins; under contention the port that did not win
// last time is chosen.
// ---------------------------------------------------------------------------
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_pick
    localparam logic OTHER = (gi == 0) ? PORT1 : PORT0;
    // Win if the other port is quiet, or if the other port had the last turn.
    assign grant_o[gi] = valid_i[gi] & (~valid_i[OTHER] | (last_grant_i == OTHER));
  end

endmodule : rr_arbiter2

// File: rtl/regfile_access_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_access_arbiter
// Shares a single-port register file between two requesters (port 0: system
// controller, port 1: debug/config loader). One transaction at a time,
// round-robin arbitration, bounded wait for read data, one response pulse
// back to the winner.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQx_VALID/WR/ADDR/WDATA request from port x (WR=1 write, 0 read)
//   REQx_READY               combinational accept, only in IDLE
//   RESPx_VALID              one-cycle completion pulse to port x
//   RESP_DATA, RESP_ERR      read data / timeout flag, valid with RESPx_VALID
//   RegFile_*                register-file strobes, address, data, valid
// ---------------------------------------------------------------------------
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  REQ0_VALID,
  input  logic                  REQ0_WR,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  output logic                  REQ0_READY,
  output logic                  RESP0_VALID,

  input  logic                  REQ1_VALID,
  input  logic                  REQ1_WR,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  output logic                  REQ1_READY,
  output logic                  RESP1_VALID,

  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RESP_ERR,

  output logic [ADDR_WIDTH-1:0] RegFile_ADDRESS,
  output logic                  RegFile_WrEn,
  output logic                  RegFile_RdEn,
  output logic [DATA_WIDTH-1:0] RegFile_WrData,
  input  logic [DATA_WIDTH-1:0] RegFile_RdData,
  input  logic                  RegFile_DATA_VALID
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // State and latched transaction
  // -------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    winner_q, winner_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic [1:0] ready_vec;
  logic [1:0] resp_vec;
  logic       idle_active;
  logic       resp_active;

  assign req_valid = {REQ1_VALID, REQ0_VALID};

  rr_arbiter2 u_rr (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          winner_d = grant[1] ? PORT1 : PORT0;
          wr_d     = grant[1] ? REQ1_WR    : REQ0_WR;
          addr_d   = grant[1] ? REQ1_ADDR  : REQ0_ADDR;
          wdata_d  = grant[1] ? REQ1_WDATA : REQ0_WDATA;
          state_d  = (grant[1] ? REQ1_WR : REQ0_WR) ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        data_d  = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end

      ST_READ: begin
        // A valid flag arriving together with the read strobe belongs to
        // no outstanding read, so it is not looked at here.
        cnt_d   = '0;
        state_d = ST_WAIT_RD;
      end

      ST_WAIT_RD: begin
        // Valid is tested first so it wins over the final timeout count.
        if (RegFile_DATA_VALID) begin
          data_d  = RegFile_RdData;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        last_grant_d = winner_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      winner_q     <= PORT0;
      last_grant_q <= PORT1;   // port 0 wins the first contention
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything is forced low while RST is high so an abandoned
  // transaction cannot leak a strobe, handshake or response.
  // -------------------------------------------------------------------------
  assign idle_active = ~RST & (state_q == ST_IDLE);
  assign resp_active = ~RST & (state_q == ST_RESP);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ready_vec[gi] = idle_active & grant[gi];
    assign resp_vec[gi]  = resp_active & (winner_q == 1'(gi));
  end

  assign REQ0_READY  = ready_vec[0];
  assign REQ1_READY  = ready_vec[1];
  assign RESP0_VALID = resp_vec[0];
  assign RESP1_VALID = resp_vec[1];

  always_comb begin
    RegFile_WrEn    = 1'b0;
    RegFile_RdEn    = 1'b0;
    RegFile_ADDRESS = '0;
    RegFile_WrData  = '0;
    RESP_DATA       = '0;
    RESP_ERR        = 1'b0;

    if (!RST) begin
      unique case (state_q)
        ST_WRITE: begin
          RegFile_WrEn    = 1'b1;
          RegFile_ADDRESS = addr_q;
          RegFile_WrData  = wdata_q;
        end
        ST_READ: begin
          RegFile_RdEn    = 1'b1;
          RegFile_ADDRESS = addr_q;
        end
        ST_RESP: begin
          RESP_DATA = data_q;
          RESP_ERR  = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule : regfile_access_arbiter

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;
  import regfile_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;
  localparam int OW = 4 + DW + 1 + AW + 2 + DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ0_WR, REQ0_READY, RESP0_VALID;
  logic [AW-1:0] REQ0_ADDR;
  logic [DW-1:0] REQ0_WDATA;
  logic          REQ1_VALID, REQ1_WR, REQ1_READY, RESP1_VALID;
  logic [AW-1:0] REQ1_ADDR;
  logic [DW-1:0] REQ1_WDATA;
  logic [DW-1:0] RESP_DATA;
  logic          RESP_ERR;
  logic [AW-1:0] RegFile_ADDRESS;
  logic          RegFile_WrEn, RegFile_RdEn;
  logic [DW-1:0] RegFile_WrData;
  logic [DW-1:0] RegFile_RdData;
  logic          RegFile_DATA_VALID;

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_WR(REQ0_WR), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY), .RESP0_VALID(RESP0_VALID),
    .REQ1_VALID(REQ1_VALID), .REQ1_WR(REQ1_WR), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY), .RESP1_VALID(RESP1_VALID),
    .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR),
    .RegFile_ADDRESS(RegFile_ADDRESS), .RegFile_WrEn(RegFile_WrEn),
    .RegFile_RdEn(RegFile_RdEn), .RegFile_WrData(RegFile_WrData),
    .RegFile_RdData(RegFile_RdData), .RegFile_DATA_VALID(RegFile_DATA_VALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]    onehot;
    logic [DW-1:0] data;
    logic          err;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [OW-1:0] all_outs();
    return {REQ0_READY, REQ1_READY, RESP0_VALID, RESP1_VALID, RESP_DATA, RESP_ERR,
            RegFile_ADDRESS, RegFile_WrEn, RegFile_RdEn, RegFile_WrData};
  endfunction

  task automatic idle_inputs();
    REQ0_VALID = 0; REQ0_WR = 0; REQ0_ADDR = '0; REQ0_WDATA = '0;
    REQ1_VALID = 0; REQ1_WR = 0; REQ1_ADDR = '0; REQ1_WDATA = '0;
    RegFile_DATA_VALID = 0; RegFile_RdData = '0;
  endtask

  // One complete transaction on port p. rd_lat = WAIT_RD index at which the
  // register file answers (-1 = never). contend raises the other port too in
  // the accept cycle; junk raises a bogus valid during the READ cycle.
  task automatic do_txn(input string nm, input int p, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int rd_lat, input logic [DW-1:0] rd_data,
                        input bit contend, input bit junk);
    exp_t e, g;
    int strobes;
    bit done;
    logic [1:0] rdy, exp_rdy;
    logic [AW+DW+1:0] strb, exp_strb;
    @(negedge CLK);
    if (p == 0 || contend) begin
      REQ0_VALID = 1; REQ0_WR = (p == 0) ? wr : 1'b0;
      REQ0_ADDR = (p == 0) ? addr : ~addr; REQ0_WDATA = wdata;
    end
    if (p == 1 || contend) begin
      REQ1_VALID = 1; REQ1_WR = (p == 1) ? wr : 1'b0;
      REQ1_ADDR = (p == 1) ? addr : ~addr; REQ1_WDATA = wdata;
    end
    #1;
    rdy = {REQ1_READY, REQ0_READY};
    exp_rdy = (p == 1) ? 2'b10 : 2'b01;
    n_cmp++;
    if (rdy !== exp_rdy) begin
      n_bad++;
      $display("FAIL %s accept: ready=%b expected %b", nm, rdy, exp_rdy);
    end
    e.onehot = exp_rdy;
    e.acc = cyc;
    if (wr) begin
      e.data = '0; e.err = 0; e.lat = 2;
    end else if (rd_lat >= 0 && rd_lat < TO) begin
      e.data = rd_data; e.err = 0; e.lat = 3 + rd_lat;
    end else begin
      e.data = '0; e.err = 1; e.lat = TO + 2;
    end
    sb.push_back(e);
    strobes = 0;
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge CLK);
      REQ0_VALID = 0; REQ1_VALID = 0;
      RegFile_DATA_VALID = (!wr && rd_lat >= 0 && k == 2 + rd_lat) || (junk && k == 1);
      RegFile_RdData = (junk && k == 1) ? 8'hEE : (RegFile_DATA_VALID ? rd_data : 8'h00);
      #1;
      if (RegFile_WrEn || RegFile_RdEn) strobes++;
      if (k == 1) begin
        strb = {RegFile_WrEn, RegFile_RdEn, RegFile_ADDRESS, RegFile_WrData};
        exp_strb = wr ? {1'b1, 1'b0, addr, wdata} : {1'b0, 1'b1, addr, {DW{1'b0}}};
        n_cmp++;
        if (strb !== exp_strb) begin
          n_bad++;
          $display("FAIL %s strobe: got %h expected %h", nm, strb, exp_strb);
        end
      end
      if (RESP0_VALID || RESP1_VALID) begin
        done = 1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL %s resp: unexpected response, scoreboard empty", nm);
        end else begin
          g = sb.pop_front();
          if ({RESP1_VALID, RESP0_VALID} !== g.onehot) begin
            n_bad++;
            $display("FAIL %s resp_port: got %b expected %b", nm, {RESP1_VALID, RESP0_VALID}, g.onehot);
          end
          n_cmp++;
          if (RESP_DATA !== g.data) begin
            n_bad++;
            $display("FAIL %s resp_data: got %h expected %h", nm, RESP_DATA, g.data);
          end
          n_cmp++;
          if (RESP_ERR !== g.err) begin
            n_bad++;
            $display("FAIL %s resp_err: got %b expected %b", nm, RESP_ERR, g.err);
          end
          n_cmp++;
          if (cyc - g.acc !== g.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d expected %0d", nm, cyc - g.acc, g.lat);
          end
        end
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s no_resp: no response within 40 cycles, expected latency %0d", nm, e.lat);
      sb.delete();
    end
    n_cmp++;
    if (strobes !== 1) begin
      n_bad++;
      $display("FAIL %s strobe_count: got %0d expected 1", nm, strobes);
    end
    $display("txn %s port=%0d wr=%0d addr=%h data=%h err=%0d lat=%0d", nm, p, wr, addr,
             RESP_DATA, RESP_ERR, cyc - e.acc);
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [OW-1:0] o;
    idle_inputs();
    RST = 1;
    REQ0_VALID = 1; REQ1_VALID = 1; REQ0_WR = 1; REQ1_WR = 1;
    REQ0_ADDR = 4'h7; REQ0_WDATA = 8'hFF;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    o = all_outs();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got %h expected 0", o);
    end
    $display("txn reset outputs=%h", o);
    idle_inputs();
    RST = 0;
    @(negedge CLK);
    #1;
    o = all_outs();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL reset idle_outputs: got %h expected 0", o);
    end
  endtask

  task automatic test_write();
    do_txn("write_p0", 0, 1'b1, 4'h3, 8'h5A, -1, 8'h00, 0, 0);
  endtask

  task automatic test_read();
    do_txn("read_p1", 1, 1'b0, 4'h3, 8'h00, 0, 8'h5A, 0, 0);
    do_txn("read_p0_n4_junk", 0, 1'b0, 4'h9, 8'h00, 4, 8'h3C, 0, 1);
  endtask

  task automatic test_timeout();
    do_txn("timeout_p0", 0, 1'b0, 4'hA, 8'h00, -1, 8'h00, 0, 0);
    do_txn("after_timeout", 0, 1'b1, 4'hB, 8'h77, -1, 8'h00, 0, 0);
  endtask

  task automatic test_valid_on_last();
    do_txn("valid_last", 1, 1'b0, 4'h6, 8'h00, TO - 1, 8'hC3, 0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    int grants, resps, exp_port;
    logic [1:0] rdy;
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    REQ0_WR = 1; REQ0_ADDR = 4'h1; REQ0_WDATA = 8'h11;
    REQ1_WR = 1; REQ1_ADDR = 4'h2; REQ1_WDATA = 8'h22;
    grants = 0; resps = 0; exp_port = 0;
    sb.delete();
    for (int c = 0; c < 40 && resps < 4; c++) begin
      if (c != 0) @(negedge CLK);
      REQ0_VALID = (grants < 4); REQ1_VALID = (grants < 4);
      #1;
      rdy = {REQ1_READY, REQ0_READY};
      n_cmp++;
      if (rdy === 2'b11) begin
        n_bad++;
        $display("FAIL b2b ready_exclusive: ready=%b expected at most one", rdy);
      end
      if (rdy == 2'b01 || rdy == 2'b10) begin
        n_cmp++;
        if (rdy !== ((exp_port == 1) ? 2'b10 : 2'b01)) begin
          n_bad++;
          $display("FAIL b2b grant%0d: ready=%b expected port %0d", grants, rdy, exp_port);
        end
        e.onehot = (exp_port == 1) ? 2'b10 : 2'b01;
        e.data = '0; e.err = 0; e.acc = cyc; e.lat = 2;
        sb.push_back(e);
        grants++;
        exp_port = 1 - exp_port;
      end
      if (RESP0_VALID || RESP1_VALID) begin
        resps++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL b2b resp: unexpected response, scoreboard empty");
        end else begin
          g = sb.pop_front();
          if ({RESP1_VALID, RESP0_VALID} !== g.onehot) begin
            n_bad++;
            $display("FAIL b2b resp_port: got %b expected %b", {RESP1_VALID, RESP0_VALID}, g.onehot);
          end
          n_cmp++;
          if (cyc - g.acc !== g.lat) begin
            n_bad++;
            $display("FAIL b2b latency: got %0d expected %0d", cyc - g.acc, g.lat);
          end
          $display("txn b2b resp=%b err=%0d lat=%0d", {RESP1_VALID, RESP0_VALID}, RESP_ERR, cyc - g.acc);
        end
      end
    end
    n_cmp++;
    if (resps !== 4) begin
      n_bad++;
      $display("FAIL b2b resp_count: got %0d expected 4", resps);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] o;
    int pulses;
    // Leave last_grant pointing at port 0 so only a proper reset makes
    // port 0 win the contention below.
    do_txn("pre_reset_p0", 0, 1'b1, 4'h4, 8'h44, -1, 8'h00, 0, 0);
    @(negedge CLK);
    REQ1_VALID = 1; REQ1_WR = 0; REQ1_ADDR = 4'h5;
    #1;
    n_cmp++;
    if (REQ1_READY !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid accept: ready1=%b expected 1", REQ1_READY);
    end
    @(negedge CLK);            // READ
    REQ1_VALID = 0;
    @(negedge CLK);            // WAIT_RD
    @(negedge CLK);            // WAIT_RD, reset now
    RST = 1;
    @(negedge CLK);
    #1;
    o = all_outs();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid outputs_in_reset: got %h expected 0", o);
    end
    RST = 0;
    #1;
    o = all_outs();
    n_cmp++;
    if (o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid outputs_after: got %h expected 0", o);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      RegFile_DATA_VALID = 1; RegFile_RdData = 8'h99;
      #1;
      if (RESP0_VALID || RESP1_VALID || RegFile_WrEn || RegFile_RdEn) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL rst_mid stray_activity: got %0d cycles expected 0", pulses);
    end
    $display("txn rst_mid abandoned stray=%0d", pulses);
    idle_inputs();
    do_txn("post_reset_contend", 0, 1'b1, 4'h8, 8'h81, -1, 8'h00, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_valid_on_last();
    test_back_to_back();
    test_reset_mid();
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_access_arbiter

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the single-port register file between two requesters.
  - Port 0: the system controller command path.
  - Port 1: a secondary master such as a debug/config loader.
- Accepts one read or write transaction at a time using round-robin arbitration.
- Drives the register-file enables, address and write data, and waits for the read-valid flag with a bounded timeout.
- Returns one response pulse, carrying read data or an error, to the requester that was granted.

Parameters:
- DATA_WIDTH, 8: register-file data width.
- ADDR_WIDTH, 4: register-file address width.
- TIMEOUT, 15: maximum number of WAIT_RD cycles before a read is aborted with an error (range 1..255).

Ports:
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- REQ0_VALID  in  1  port 0 request pending.
- REQ0_WR  in  1  port 0 direction: 1 = write, 0 = read.
- REQ0_ADDR  in  ADDR_WIDTH  port 0 address.
- REQ0_WDATA  in  DATA_WIDTH  port 0 write data.
- REQ0_READY  out  1  port 0 request accepted this cycle.
- RESP0_VALID  out  1  port 0 transaction complete, one-cycle pulse.
- REQ1_VALID, REQ1_WR, REQ1_ADDR, REQ1_WDATA, REQ1_READY, RESP1_VALID: same as the port 0 signals, for port 1.
- RESP_DATA  out  DATA_WIDTH  read data, meaningful while RESPx_VALID is high.
- RESP_ERR  out  1  read timeout flag, meaningful while RESPx_VALID is high.
- RegFile_ADDRESS  out  ADDR_WIDTH  register-file address.
- RegFile_WrEn  out  1  register-file write strobe.
- RegFile_RdEn  out  1  register-file read strobe.
- RegFile_WrData  out  DATA_WIDTH  register-file write data.
- RegFile_RdData  in  DATA_WIDTH  register-file read data.
- RegFile_DATA_VALID  in  1  read data valid flag.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE, the timeout counter is 0, and last_grant is 1, so port 0 wins the first contention.
  - Reset mid-transaction abandons the transaction: no RESP pulse is issued and no strobe persists on the next cycle.
- States: IDLE, WRITE, READ, WAIT_RD, RESP.
- IDLE:
  - If only one REQx_VALID is high, that port wins.
  - If both are high, the port other than last_grant wins.
  - REQx_READY for the winner is driven combinationally high in this same cycle; that is the handshake.
  - The winner's WR, ADDR and WDATA are latched.
  - Next state is WRITE if WR=1, otherwise READ.
  - With no request pending, the block stays in IDLE.
  - REQx_READY is never high outside IDLE, and never high for both ports together.
- WRITE:
  - RegFile_WrEn=1 for exactly one cycle, with the latched address and data.
  - Next state RESP, with RESP_ERR=0 and RESP_DATA=0.
- READ:
  - RegFile_RdEn=1 for exactly one cycle with the latched address.
  - The timeout counter is cleared.
  - Next state WAIT_RD.
  - RegFile_DATA_VALID seen in this cycle is ignored.
- WAIT_RD:
  - If RegFile_DATA_VALID=1, capture RegFile_RdData, set err=0 and go to RESP.
  - Else if counter==TIMEOUT-1, set data=0, err=1 and go to RESP.
  - Else increment the counter.
  - When the valid flag and the final count coincide, valid wins.
- RESP:
  - RESPx_VALID=1 for one cycle to the latched winner only, with RESP_DATA and RESP_ERR held.
  - last_grant is updated to the winner; next state IDLE.
- Latency from accept (IDLE) to response:
  - Write: RESP 2 cycles after accept.
  - Read: RESP 3+N cycles after accept, where N is the number of WAIT_RD cycles before valid (N=0 when valid arrives in the first WAIT_RD cycle).
  - Read timeout: RESP TIMEOUT+2 cycles after accept.
- The address and data outputs are 0 whenever their strobe is low.
- RegFile_DATA_VALID outside WAIT_RD is ignored.
- A requester may drop VALID after acceptance without effect. It must hold its request stable while VALID is high and READY is low.

Decomposition:
- Package regfile_arb_pkg holds:
  - the state enum;
  - PORT0/PORT1 grant constants;
  - the default TIMEOUT.
- One sub-module, rr_arbiter2: a combinational two-way round-robin pick from the two valid bits and last_grant, outputting grant one-hot.

Test Plan:
- Port 0 write addr 0x3, data 0x5A, port 1 idle:
  - REQ0_READY pulses.
  - Next cycle RegFile_WrEn=1 with ADDR=0x3 and WrData=0x5A.
  - RESP0_VALID pulses 2 cycles after accept with ERR=0.
- Port 1 read addr 0x3, register file returns 0x5A with valid on the first WAIT_RD cycle:
  - RegFile_RdEn pulses once.
  - RESP1_VALID pulses 3 cycles after accept with RESP_DATA=0x5A and ERR=0.
- Both ports request every cycle from reset:
  - Grants alternate 0,1,0,1.
  - READY is never high on both ports simultaneously.
  - Each RESP goes only to the granted port.
- Read with RegFile_DATA_VALID never asserted, TIMEOUT=15:
  - RESP0_VALID pulses 17 cycles after accept with DATA=0x00 and ERR=1.
  - The next request is then accepted normally.
- RegFile_DATA_VALID asserted on the final timeout cycle with data 0xC3:
  - Response carries DATA=0xC3 and ERR=0.
- RST asserted during WAIT_RD:
  - All outputs are 0 the next cycle and no RESP pulse is issued.
  - After RST drops, port 0 wins a simultaneous request.
